// File: rtl/stack_rpn_ctrl_pkg.sv
// Shared definitions for the RPN stack controller: operator codes, FSM state
// encoding and the default data width.
package stack_rpn_ctrl_pkg;

    localparam int DW_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;
    localparam logic [2:0] OP_EQ  = 3'd5;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PUSH     = 4'd1,
        ST_POP_B    = 4'd2,
        ST_WAIT_B   = 4'd3,
        ST_POP_A    = 4'd4,
        ST_WAIT_A   = 4'd5,
        ST_PUSH_RES = 4'd6,
        ST_POP_FIN  = 4'd7,
        ST_WAIT_FIN = 4'd8,
        ST_DONE     = 4'd9,
        ST_ERR      = 4'd10
    } state_e;

    // Codes above EQ are reserved and count as a malformed expression.
    function automatic logic is_legal_op(input logic [2:0] op);
        return (op <= OP_EQ);
    endfunction

endpackage

// File: rtl/rpn_alu.sv
// Combinational operator evaluation for the RPN controller; A is the deeper
// operand, B the top of stack, and results wrap modulo 2^DW.
module rpn_alu
    import stack_rpn_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [2:0]    op,
    output logic [DW-1:0] y
);

    // Operator select; non-arithmetic codes never reach a result push.
    always_comb begin
        y = {DW{1'b0}};
        case (op)
            OP_ADD:  y = a + b;
            OP_SUB:  y = a - b;
            OP_AND:  y = a & b;
            OP_OR:   y = a | b;
            OP_XOR:  y = a ^ b;
            default: y = {DW{1'b0}};
        endcase
    end

endmodule

// File: rtl/stack_rpn_ctrl.sv
// RPN token evaluator that masters a push/pop stack: accepts operand/operator
// tokens, sequences stack accesses and reports the expression value.
module stack_rpn_ctrl
    import stack_rpn_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF
) (
    input  logic          Clk,
    input  logic          RstN,
    input  logic          Tok_Valid,
    output logic          Tok_Ready,
    input  logic          Tok_IsOp,
    input  logic [DW-1:0] Tok_Data,
    output logic [DW-1:0] Stk_Data_In,
    output logic          Stk_Push,
    output logic          Stk_Pop,
    input  logic [DW-1:0] Stk_Data_Out,
    input  logic          Stk_Full,
    input  logic          Stk_Empty,
    output logic [DW-1:0] Result,
    output logic          Result_Valid,
    output logic          Error
);

    state_e        state_r;
    logic [2:0]    op_r;
    logic [DW-1:0] b_r;
    logic [DW-1:0] data_in_r;
    logic [DW-1:0] result_r;
    logic          push_r;
    logic          pop_r;
    logic          result_valid_r;
    logic          error_r;
    logic          accept_s;
    logic [DW-1:0] alu_y_s;

    // RstN is an active-high reset despite its name, so it also blocks acceptance.
    assign Tok_Ready    = (state_r == ST_IDLE) & ~error_r & ~RstN;
    assign accept_s     = Tok_Valid & Tok_Ready;
    assign Stk_Data_In  = data_in_r;
    assign Stk_Push     = push_r;
    assign Stk_Pop      = pop_r;
    assign Result       = result_r;
    assign Result_Valid = result_valid_r;
    assign Error        = error_r;

    rpn_alu #(.DW(DW)) u_alu (
        .a  (Stk_Data_Out),
        .b  (b_r),
        .op (op_r),
        .y  (alu_y_s)
    );

    // Token sequencer; push/pop strobes default low so each lasts one cycle.
    always_ff @(posedge Clk) begin
        if (RstN) begin
            state_r        <= ST_IDLE;
            op_r           <= 3'd0;
            b_r            <= {DW{1'b0}};
            data_in_r      <= {DW{1'b0}};
            result_r       <= {DW{1'b0}};
            push_r         <= 1'b0;
            pop_r          <= 1'b0;
            result_valid_r <= 1'b0;
            error_r        <= 1'b0;
        end else begin
            push_r         <= 1'b0;
            pop_r          <= 1'b0;
            result_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        if (!Tok_IsOp) begin
                            if (Stk_Full) begin
                                state_r <= ST_ERR;
                                error_r <= 1'b1;
                            end else begin
                                state_r   <= ST_PUSH;
                                push_r    <= 1'b1;
                                data_in_r <= Tok_Data;
                            end
                        end else if (!is_legal_op(Tok_Data[2:0]) || Stk_Empty) begin
                            state_r <= ST_ERR;
                            error_r <= 1'b1;
                        end else begin
                            op_r    <= Tok_Data[2:0];
                            pop_r   <= 1'b1;
                            state_r <= (Tok_Data[2:0] == OP_EQ) ? ST_POP_FIN : ST_POP_B;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_PUSH:     state_r <= ST_IDLE;
                ST_POP_B:    state_r <= ST_WAIT_B;
                ST_WAIT_B: begin
                    b_r <= Stk_Data_Out;
                    // Nothing left for A: the operator had only one operand.
                    if (Stk_Empty) begin
                        state_r <= ST_ERR;
                        error_r <= 1'b1;
                    end else begin
                        state_r <= ST_POP_A;
                        pop_r   <= 1'b1;
                    end
                end
                ST_POP_A:    state_r <= ST_WAIT_A;
                ST_WAIT_A: begin
                    state_r   <= ST_PUSH_RES;
                    push_r    <= 1'b1;
                    data_in_r <= alu_y_s;
                end
                ST_PUSH_RES: state_r <= ST_IDLE;
                ST_POP_FIN:  state_r <= ST_WAIT_FIN;
                ST_WAIT_FIN: begin
                    if (!Stk_Empty) begin
                        state_r <= ST_ERR;
                        error_r <= 1'b1;
                    end else begin
                        state_r        <= ST_DONE;
                        result_r       <= Stk_Data_Out;
                        result_valid_r <= 1'b1;
                    end
                end
                ST_DONE:     state_r <= ST_IDLE;
                ST_ERR: begin
                    state_r <= ST_ERR;
                    error_r <= 1'b1;
                end
                default: begin
                    state_r <= ST_ERR;
                    error_r <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_rpn_ctrl.sv
// Self-checking bench for stack_rpn_ctrl: a depth-8 stack model answers the
// controller, and a queue-based RPN evaluator predicts every expression.
module tb_stack_rpn_ctrl;

    logic       clk = 1'b0;
    logic       rstn = 1'b1;
    logic       tok_valid = 1'b0;
    logic       tok_ready;
    logic       tok_isop = 1'b0;
    logic [3:0] tok_data = 4'd0;
    logic [3:0] stk_din;
    logic       stk_push;
    logic       stk_pop;
    logic [3:0] stk_dout = 4'd0;
    logic       stk_full;
    logic       stk_empty;
    logic [3:0] result;
    logic       result_valid;
    logic       error;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stack_rpn_ctrl #(.DW(4)) dut (
        .Clk          (clk),
        .RstN         (rstn),
        .Tok_Valid    (tok_valid),
        .Tok_Ready    (tok_ready),
        .Tok_IsOp     (tok_isop),
        .Tok_Data     (tok_data),
        .Stk_Data_In  (stk_din),
        .Stk_Push     (stk_push),
        .Stk_Pop      (stk_pop),
        .Stk_Data_Out (stk_dout),
        .Stk_Full     (stk_full),
        .Stk_Empty    (stk_empty),
        .Result       (result),
        .Result_Valid (result_valid),
        .Error        (error)
    );

    // Depth-8 stack, reset together with the controller
    logic [3:0] mem [8];
    logic [3:0] cnt = 4'd0;
    always @(posedge clk) begin
        if (rstn) begin
            cnt <= 4'd0;
        end else if (stk_push && cnt < 4'd8) begin
            mem[cnt[2:0]] <= stk_din;
            cnt <= cnt + 4'd1;
        end else if (stk_pop && cnt > 4'd0) begin
            stk_dout <= mem[cnt[2:0] - 3'd1];
            cnt <= cnt - 4'd1;
        end
    end
    assign stk_full  = (cnt == 4'd8);
    assign stk_empty = (cnt == 4'd0);

    // Protocol monitor (cumulative counters, sampled on the falling edge)
    int   push_cnt = 0;
    int   rv_cnt = 0;
    int   viol_cnt = 0;
    logic prev_push = 1'b0, prev_pop = 1'b0, prev_rv = 1'b0;
    always @(negedge clk) begin
        if (stk_push) push_cnt <= push_cnt + 1;
        if (result_valid) rv_cnt <= rv_cnt + 1;
        if ((stk_push && stk_full) || (stk_push && stk_pop) || (stk_push && prev_push) ||
            (stk_pop && prev_pop) || (result_valid && prev_rv))
            viol_cnt <= viol_cnt + 1;
        prev_push <= stk_push;
        prev_pop  <= stk_pop;
        prev_rv   <= result_valid;
    end

    logic       q_isop [$];
    logic [3:0] q_data [$];

    task automatic add_tok(input logic isop, input logic [3:0] data);
        q_isop.push_back(isop);
        q_data.push_back(data);
    endtask

    task automatic do_reset();
        @(negedge clk);
        tok_valid = 1'b0;
        rstn = 1'b1;
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
    endtask

    // Present one token; ok=0 if the controller never became ready.
    task automatic send_token(input logic isop, input logic [3:0] data, output bit ok);
        int n = 0;
        @(negedge clk);
        tok_valid = 1'b1;
        tok_isop  = isop;
        tok_data  = data;
        while (!tok_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = tok_ready;
        @(posedge clk);
        #1;
        tok_valid = 1'b0;
        tok_isop  = 1'($urandom);
        tok_data  = 4'($urandom);
    endtask

    task automatic run_expr();
        bit ok;
        foreach (q_isop[i]) begin
            send_token(q_isop[i], q_data[i], ok);
            if (!ok) break;
        end
        repeat (10) @(negedge clk);
        q_isop.delete();
        q_data.delete();
    endtask

    // Reference evaluator over the queued tokens, working on a plain value stack.
    task automatic model_eval(output bit m_err, output logic [3:0] m_res,
                              output int m_rv, output int m_push, output int m_depth);
        logic [3:0] st [$];
        logic [3:0] a, b, r;
        logic [2:0] op;
        m_err = 1'b0; m_res = 4'd0; m_rv = 0; m_push = 0;
        foreach (q_isop[i]) begin
            if (m_err) break;
            if (!q_isop[i]) begin
                if (st.size() == 8) m_err = 1'b1;
                else begin st.push_back(q_data[i]); m_push++; end
            end else begin
                op = q_data[i][2:0];
                if (op > 3'd5 || st.size() == 0) m_err = 1'b1;
                else if (op == 3'd5) begin
                    if (st.size() != 1) m_err = 1'b1;
                    else begin m_res = st.pop_back(); m_rv++; end
                end else if (st.size() < 2) m_err = 1'b1;
                else begin
                    b = st.pop_back();
                    a = st.pop_back();
                    case (op)
                        3'd0:    r = a + b;
                        3'd1:    r = a - b;
                        3'd2:    r = a & b;
                        3'd3:    r = a | b;
                        default: r = a ^ b;
                    endcase
                    st.push_back(r);
                    m_push++;
                end
            end
        end
        m_depth = st.size();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (tok_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", tok_ready); end
        checks++; if (stk_push !== 1'b0 || stk_pop !== 1'b0) begin errors++; $display("FAIL reset_strobes: got push=%b pop=%b expected 0 0", stk_push, stk_pop); end
        checks++; if (result_valid !== 1'b0 || error !== 1'b0) begin errors++; $display("FAIL reset_flags: got rv=%b err=%b expected 0 0", result_valid, error); end
        checks++; if (result !== 4'd0 || stk_din !== 4'd0) begin errors++; $display("FAIL reset_data: got result=%0d din=%0d expected 0 0", result, stk_din); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready: got %b expected 1", tok_ready); end
    endtask

    task automatic test_simple(input string name, input logic [3:0] x, input logic [3:0] y,
                               input logic [3:0] op, input logic [3:0] exp_res);
        int p0, r0;
        do_reset();
        p0 = push_cnt; r0 = rv_cnt;
        add_tok(1'b0, x); add_tok(1'b0, y); add_tok(1'b1, op); add_tok(1'b1, 4'd5);
        run_expr();
        checks++; if (result !== exp_res) begin errors++; $display("FAIL %s_result: got %0d expected %0d", name, result, exp_res); end
        checks++; if (rv_cnt - r0 != 1) begin errors++; $display("FAIL %s_valid_pulses: got %0d expected 1", name, rv_cnt - r0); end
        checks++; if (error !== 1'b0 || stk_empty !== 1'b1) begin errors++; $display("FAIL %s_end_state: got err=%b empty=%b expected 0 1", name, error, stk_empty); end
        checks++; if (push_cnt - p0 != 3) begin errors++; $display("FAIL %s_pushes: got %0d expected 3", name, push_cnt - p0); end
    endtask

    task automatic test_underflow();
        int p0, r0;
        do_reset();
        p0 = push_cnt; r0 = rv_cnt;
        add_tok(1'b0, 4'd6); add_tok(1'b1, 4'd0);
        run_expr();
        checks++; if (error !== 1'b1 || tok_ready !== 1'b0) begin errors++; $display("FAIL underflow_error: got err=%b ready=%b expected 1 0", error, tok_ready); end
        checks++; if (push_cnt - p0 != 1 || rv_cnt - r0 != 0) begin errors++; $display("FAIL underflow_traffic: got pushes=%0d rv=%0d expected 1 0", push_cnt - p0, rv_cnt - r0); end
    endtask

    task automatic test_overflow();
        int p0, v0;
        do_reset();
        p0 = push_cnt; v0 = viol_cnt;
        for (int i = 0; i < 9; i++) add_tok(1'b0, 4'(i + 1));
        run_expr();
        checks++; if (push_cnt - p0 != 8) begin errors++; $display("FAIL overflow_pushes: got %0d expected 8", push_cnt - p0); end
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL overflow_error: got %b expected 1", error); end
        checks++; if (viol_cnt != v0) begin errors++; $display("FAIL overflow_protocol: got %0d violations expected 0", viol_cnt - v0); end
    endtask

    task automatic test_leftover();
        int r0;
        do_reset();
        r0 = rv_cnt;
        add_tok(1'b0, 4'd1); add_tok(1'b0, 4'd2); add_tok(1'b1, 4'd5);
        run_expr();
        checks++; if (error !== 1'b1 || rv_cnt != r0) begin errors++; $display("FAIL leftover: got err=%b rv=%0d expected 1 0", error, rv_cnt - r0); end
        do_reset();
        add_tok(1'b0, 4'd1); add_tok(1'b1, 4'd7);
        run_expr();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL illegal_op: got err=%b expected 1", error); end
    endtask

    task automatic test_reset_mid_op();
        bit ok;
        do_reset();
        send_token(1'b0, 4'd3, ok);
        send_token(1'b0, 4'd4, ok);
        send_token(1'b1, 4'd0, ok);
        repeat (3) @(negedge clk);
        checks++; if (stk_pop !== 1'b1) begin errors++; $display("FAIL midreset_pop_a: got pop=%b expected 1", stk_pop); end
        rstn = 1'b1;
        @(negedge clk);
        checks++; if (stk_pop !== 1'b0 || error !== 1'b0 || tok_ready !== 1'b0) begin errors++; $display("FAIL midreset_after: got pop=%b err=%b ready=%b expected 0 0 0", stk_pop, error, tok_ready); end
        rstn = 1'b0;
        @(negedge clk);
        checks++; if (tok_ready !== 1'b1) begin errors++; $display("FAIL midreset_idle: got ready=%b expected 1", tok_ready); end
        add_tok(1'b0, 4'd3); add_tok(1'b0, 4'd4); add_tok(1'b1, 4'd4); add_tok(1'b1, 4'd5);
        run_expr();
        checks++; if (result !== 4'd7 || error !== 1'b0) begin errors++; $display("FAIL midreset_fresh: got result=%0d err=%b expected 7 0", result, error); end
    endtask

    task automatic test_random();
        bit         m_err;
        logic [3:0] m_res;
        int         m_rv, m_push, m_depth, d, n, p0, r0, v0, k;
        for (int it = 0; it < 30; it++) begin
            do_reset();
            d = 0;
            n = $urandom_range(2, 9);
            for (int t = 0; t < n; t++) begin
                if (d < 2 || ($urandom_range(0, 2) == 0 && d < 6)) begin
                    add_tok(1'b0, 4'($urandom)); d++;
                end else begin
                    add_tok(1'b1, 4'($urandom_range(0, 4))); d--;
                end
            end
            while (d > 1) begin add_tok(1'b1, 4'($urandom_range(0, 4))); d--; end
            add_tok(1'b1, 4'd5);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, q_isop.size() - 1);
                q_isop[k] = 1'($urandom);
                q_data[k] = 4'($urandom);
            end
            model_eval(m_err, m_res, m_rv, m_push, m_depth);
            p0 = push_cnt; r0 = rv_cnt; v0 = viol_cnt;
            run_expr();
            checks++; if (error !== m_err) begin errors++; $display("FAIL rand%0d_error: got %b expected %b", it, error, m_err); end
            checks++; if (result !== m_res || rv_cnt - r0 != m_rv) begin errors++; $display("FAIL rand%0d_result: got %0d/%0d pulses expected %0d/%0d pulses", it, result, rv_cnt - r0, m_res, m_rv); end
            checks++; if (push_cnt - p0 != m_push || viol_cnt != v0) begin errors++; $display("FAIL rand%0d_pushes: got %0d viol=%0d expected %0d viol=0", it, push_cnt - p0, viol_cnt - v0, m_push); end
            if (!m_err) begin
                checks++; if (stk_empty !== (m_depth == 0)) begin errors++; $display("FAIL rand%0d_empty: got %b expected %b", it, stk_empty, (m_depth == 0)); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_simple("add", 4'd3, 4'd4, 4'd0, 4'd7);
        test_simple("sub_wrap", 4'd2, 4'd5, 4'd1, 4'd13);
        test_simple("add_wrap", 4'd15, 4'd1, 4'd0, 4'd0);
        test_simple("and", 4'd12, 4'd10, 4'd2, 4'd8);
        test_simple("or", 4'd12, 4'd3, 4'd3, 4'd15);
        test_underflow();
        test_overflow();
        test_leftover();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/stack_rpn_ctrl.md
Name: stack_rpn_ctrl

Overview:
Initiator-side controller for the team's push/pop stack. It accepts a stream of RPN tokens (operands and operators) over a valid/ready handshake and drives the stack's Push/Pop/Data_In ports. It reads back Data_Out, Full and Empty, evaluates each operator, and reports the final expression value.
It sits between a token source and one stack instance and is the only master of that stack.

Parameters:
DW, 4, data width of operands, stack entries and result; all arithmetic is modulo 2^DW

Ports:
Clk  in  1  clock, rising edge
RstN  in  1  synchronous reset, active-high despite the name
Tok_Valid  in  1  token present
Tok_Ready  out  1  controller can accept a token this cycle
Tok_IsOp  in  1  1 = Tok_Data is an opcode, 0 = operand
Tok_Data  in  DW  operand value, or opcode in bits [2:0]
Stk_Data_In  out  DW  to stack Data_In
Stk_Push  out  1  to stack Push
Stk_Pop  out  1  to stack Pop
Stk_Data_Out  in  DW  from stack Data_Out; valid the cycle after a Pop edge
Stk_Full  in  1  from stack Full
Stk_Empty  in  1  from stack Empty
Result  out  DW  expression value, held until next EQ
Result_Valid  out  1  one-cycle pulse when Result updates
Error  out  1  sticky malformed-expression flag

Behaviour:
- Reset (RstN=1 at an edge): state IDLE; Stk_Push, Stk_Pop, Result_Valid and Error are 0; Result and Stk_Data_In are 0; Tok_Ready is 0 while RstN is high.
- Handshake: Tok_Ready = (state==IDLE) & ~Error & ~RstN. A token is accepted on an edge where Tok_Valid & Tok_Ready.
- Stack outputs are registered. Stk_Push and Stk_Pop are never both 1. Each is asserted for exactly one cycle per access.
- Opcodes: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 XOR; 5 EQ (end of expression); 6-7 illegal, go to ERR. B is the first value popped (top of stack) and A is the second.
- FSM states: IDLE, PUSH, POP_B, WAIT_B, POP_A, WAIT_A, PUSH_RES, POP_FIN, WAIT_FIN, DONE, ERR.
- Operand token, accepted in cycle T:
  - If Stk_Full=1 in T, go to ERR.
  - Otherwise the PUSH state in T+1 drives Stk_Push=1 with Stk_Data_In=Tok_Data, and the FSM returns to IDLE in T+2.
- Operator token, accepted in cycle T:
  - If Stk_Empty=1 in T, go to ERR.
  - T+1 POP_B: Stk_Pop=1.
  - T+2 WAIT_B: capture B. If Stk_Empty=1, go to ERR (underflow).
  - T+3 POP_A, T+4 WAIT_A: capture A.
  - T+5 PUSH_RES: push the result; DW-bit truncation, no carry or borrow flag.
  - T+6 IDLE.
- EQ token, accepted in cycle T:
  - If Stk_Empty=1, go to ERR.
  - T+1 POP_FIN, T+2 WAIT_FIN: capture the value. If Stk_Empty=0 after the pop (leftover operands), go to ERR.
  - T+3 DONE: Result updated, Result_Valid=1.
  - T+4 IDLE.
- ERR: Error=1 and Tok_Ready=0 until reset. No further stack accesses; the stack content is left as is.
- Reset mid-operation: the FSM returns to IDLE on the reset edge and any in-flight Push/Pop is dropped next cycle. The partial operands are discarded. The stack itself must also be reset by the system.
- Tok_Data/Tok_IsOp are captured at acceptance; changes after acceptance have no effect.

Decomposition:
- Shared package: opcode constants (OP_ADD..OP_EQ), FSM state encoding, default DW.
- One combinational sub-module, rpn_alu (A, B, opcode -> DW-bit result). The FSM and handshake stay in stack_rpn_ctrl.

Test Plan:
- Tokens 3, 4, ADD, EQ with a depth-8 stack -> Result=7 with a one-cycle Result_Valid; Error=0; Stk_Empty=1 at end.
- Tokens 2, 5, SUB, EQ -> Result=13 (2-5 mod 16). Tokens 15, 1, ADD, EQ -> Result=0.
- Tokens 6, ADD (one operand only) -> Error=1 after the POP_B/WAIT_B sequence; Tok_Ready stays 0; no push of a result.
- Nine operands into a depth-8 stack -> eight Stk_Push pulses, Error=1 on the 9th; Stk_Push is never 1 while Stk_Full=1.
- Tokens 1, 2, EQ -> Error=1 (leftover operand); Result_Valid never pulses.
- Assert RstN for one cycle during POP_A of an ADD -> Stk_Pop=0, state IDLE and Error=0 the following cycle. A fresh 3, 4, XOR, EQ sequence after stack reset yields Result=7.
